// File: rtl/conv_tile_sched.sv
// Frame sequencer for the conv/pool datapath: walks pooled pixels in raster order,
// issues tile reads, strobes the datapath and writes results with ready backpressure.
module conv_tile_sched #(
  parameter int unsigned OUT_W  = 255,
  parameter int unsigned OUT_H  = 255,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  input  logic [7:0]        pool_in,
  output logic              busy,
  output logic              done,
  output logic              input_re,
  output logic [ADDR_W-1:0] input_addr,
  output logic [7:0]        tile_col,
  output logic [7:0]        tile_row,
  output logic              calc_en,
  output logic              output_we,
  output logic [ADDR_W-1:0] output_addr,
  output logic [7:0]        y
);

  localparam int unsigned       LAT_W    = 2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUT_W * OUT_H - 1);
  localparam logic [7:0]        LAST_COL = 8'(OUT_W - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_CALC  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [7:0]        r_col, w_col_nxt;
  logic [7:0]        r_row, w_row_nxt;
  logic [LAT_W-1:0]  r_lat, w_lat_nxt;
  logic [7:0]        r_y, w_y_nxt;

  logic              r_busy, r_done, r_re, r_calc, r_we;
  logic [ADDR_W-1:0] r_iaddr, r_oaddr;
  logic              w_busy_nxt, w_done_nxt, w_re_nxt, w_calc_nxt, w_we_nxt;
  logic [ADDR_W-1:0] w_iaddr_nxt, w_oaddr_nxt;
  logic              w_accept;

  assign w_accept = r_we & out_ready;

  // Next state, counters and next-cycle registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_lat_nxt   = r_lat;
    w_y_nxt     = r_y;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_READ;
          w_idx_nxt   = '0;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end
      end
      S_READ: begin
        w_lat_nxt   = LAT_LOAD;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_lat == '0) w_state_nxt = S_CALC;
        else             w_lat_nxt   = r_lat - LAT_W'(1);
      end
      S_CALC: begin
        w_y_nxt     = pool_in;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (w_accept) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_READ;
            w_idx_nxt   = r_idx + ADDR_W'(1);
            if (r_col == LAST_COL) begin
              w_col_nxt = '0;
              w_row_nxt = r_row + 8'd1;
            end else begin
              w_col_nxt = r_col + 8'd1;
            end
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort overrides everything, including a same-cycle accept
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = r_idx;
      w_col_nxt   = r_col;
      w_row_nxt   = r_row;
      w_y_nxt     = r_y;
    end

    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_re_nxt    = (w_state_nxt == S_READ);
    w_calc_nxt  = (w_state_nxt == S_CALC);
    w_we_nxt    = (w_state_nxt == S_WRITE);
    w_iaddr_nxt = w_re_nxt ? w_idx_nxt : '0;
    w_oaddr_nxt = w_we_nxt ? w_idx_nxt : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_lat   <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_re    <= 1'b0;
      r_calc  <= 1'b0;
      r_we    <= 1'b0;
      r_iaddr <= '0;
      r_oaddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_lat   <= w_lat_nxt;
      r_y     <= w_y_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_re    <= w_re_nxt;
      r_calc  <= w_calc_nxt;
      r_we    <= w_we_nxt;
      r_iaddr <= w_iaddr_nxt;
      r_oaddr <= w_oaddr_nxt;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign input_re    = r_re;
  assign input_addr  = r_iaddr;
  assign tile_col    = r_col;
  assign tile_row    = r_row;
  assign calc_en     = r_calc;
  assign output_we   = r_we;
  assign output_addr = r_oaddr;
  assign y           = r_y;

endmodule
